glyph_writer: RTL and testbench

GLYPH_WRITER -- requirements
Module: glyph_writer

---
 rtl/glyph_writer.sv | 138 +++++++++++++
 tb/tb_glyph_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/glyph_writer.sv
// glyph_writer: copies one 32x32 1-bpp font glyph into a 640x480 framebuffer cell.
// Ports:
//   CLK, reset                      clock and asynchronous active-high reset
//   req_valid/req_ready             request handshake (ready only while idle)
//   req_col, req_row                target cell (col 0..19, row 0..14)
//   req_code, req_inv               glyph code and pixel inversion
//   font_addr/font_data             registered font ROM port, addr = {code, line}
//   fb_wraddr/fb_data/fb_wren       framebuffer write port, bit 31 = leftmost pixel
//   done, err                       completion pulse / out-of-range rejection pulse
module glyph_writer #(
  parameter int HWORDS   = 20,
  parameter int CELL_H   = 32,
  parameter int FB_DEPTH = 9600
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_col,
  input  logic [3:0]  req_row,
  input  logic [7:0]  req_code,
  input  logic        req_inv,
  output logic [12:0] font_addr,
  input  logic [31:0] font_data,
  output logic [13:0] fb_wraddr,
  output logic [31:0] fb_data,
  output logic        fb_wren,
  output logic        done,
  output logic        err
);
  localparam int CELL_WORDS = HWORDS * CELL_H;
  localparam int ROWS       = FB_DEPTH / CELL_WORDS;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic        inv_q, inv_d;
  logic [4:0]  line_q, line_d;
  logic [13:0] base_q, base_d;
  logic        ready_q, ready_d, wren_q, wren_d, done_q, done_d, err_q, err_d;
  logic [12:0] font_addr_q, font_addr_d;
  logic [13:0] wraddr_q, wraddr_d;
  logic [31:0] data_q, data_d;
  logic        in_range;
  assign in_range  = int'(req_col) < HWORDS && int'(req_row) < ROWS;
  assign req_ready = ready_q;
  assign font_addr = font_addr_q;
  assign fb_wraddr = wraddr_q;
  assign fb_data   = data_q;
  assign fb_wren   = wren_q;
  assign done      = done_q;
  assign err       = err_q;
  // Outputs are registered: each is computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    inv_d       = inv_q;
    line_d      = line_q;
    base_d      = base_q;
    font_addr_d = font_addr_q;
    wraddr_d    = wraddr_q;
    data_d      = data_q;
    ready_d     = 1'b0;
    wren_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && in_range) begin
          state_d     = FETCH;
          ready_d     = 1'b0;
          code_d      = req_code;
          inv_d       = req_inv;
          line_d      = 5'd0;
          base_d      = 14'(req_row) * 14'(CELL_WORDS) + 14'(req_col);
          font_addr_d = {req_code, 5'd0};
        end else if (req_valid) begin
          err_d = 1'b1;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        // ROM word for font_addr is valid now; it goes straight into the write register.
        state_d  = WRITE;
        wren_d   = 1'b1;
        wraddr_d = base_q + 14'(line_q) * 14'(HWORDS);
        data_d   = font_data ^ {32{inv_q}};
      end
      WRITE: begin
        if (line_q == 5'(CELL_H - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = FETCH;
          line_d      = line_q + 5'd1;
          font_addr_d = {code_q, line_q + 5'd1};
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      inv_q       <= 1'b0;
      line_q      <= '0;
      base_q      <= '0;
      font_addr_q <= '0;
      wraddr_q    <= '0;
      data_q      <= '0;
      ready_q     <= 1'b1;
      wren_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      inv_q       <= inv_d;
      line_q      <= line_d;
      base_q      <= base_d;
      font_addr_q <= font_addr_d;
      wraddr_q    <= wraddr_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      wren_q      <= wren_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_glyph_writer.sv
// tb_glyph_writer: directed self-checking bench for glyph_writer.
module tb_glyph_writer;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_col = '0;
  logic [3:0]  req_row = '0;
  logic [7:0]  req_code = '0;
  logic        req_inv = 1'b0;
  logic [12:0] font_addr;
  logic [31:0] font_data = '0;
  logic [13:0] fb_wraddr;
  logic [31:0] fb_data;
  logic        fb_wren;
  logic        done;
  logic        err;
  int          checks = 0;
  int          errors = 0;
  bit          rom_mode = 1'b0;

  glyph_writer dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_col(req_col), .req_row(req_row), .req_code(req_code), .req_inv(req_inv),
    .font_addr(font_addr), .font_data(font_data), .fb_wraddr(fb_wraddr),
    .fb_data(fb_data), .fb_wren(fb_wren), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Registered font ROM: mode 0 returns 0xA5000000|line, mode 1 returns 0x0000FFFF.
  always @(posedge CLK)
    font_data <= rom_mode ? 32'h0000FFFF : {8'hA5, 19'd0, font_addr[4:0]};

  task automatic send(input logic [4:0] c, input logic [3:0] r, input logic [7:0] code, input logic inv);
    req_col = c; req_row = r; req_code = code; req_inv = inv; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge k; checks cycles k+1..k+last at the falling edge.
  task automatic run_glyph(input string tag, input int base, input logic [7:0] code, input logic inv, input int last);
    for (int n = 1; n <= last; n++) begin
      logic        wr;
      int          l;
      logic [31:0] word;
      @(negedge CLK);
      wr   = (n >= 3 && n <= 96 && n % 3 == 0);
      l    = n / 3 - 1;
      word = (rom_mode ? 32'h0000FFFF : (32'hA5000000 | l)) ^ {32{inv}};
      checks++;
      if (fb_wren !== wr) begin errors++; $display("FAIL %s wren n=%0d got %b exp %b", tag, n, fb_wren, wr); end
      if (wr) begin
        checks++;
        if (fb_wraddr !== 14'(base + l * 20)) begin errors++; $display("FAIL %s addr line %0d got %0d exp %0d", tag, l, fb_wraddr, base + l * 20); end
        checks++;
        if (fb_data !== word) begin errors++; $display("FAIL %s data line %0d got %h exp %h", tag, l, fb_data, word); end
        checks++;
        if (fb_wraddr >= 14'd9600) begin errors++; $display("FAIL %s range got %0d exp <9600", tag, fb_wraddr); end
      end
      if (n % 3 == 1 && n <= 94) begin
        checks++;
        if (font_addr !== {code, 5'(n / 3)}) begin errors++; $display("FAIL %s font_addr n=%0d got %h exp %h", tag, n, font_addr, {code, 5'(n / 3)}); end
      end
      checks++;
      if (done !== (n == 97)) begin errors++; $display("FAIL %s done n=%0d got %b exp %b", tag, n, done, n == 97); end
      checks++;
      if (req_ready !== (n == 98)) begin errors++; $display("FAIL %s ready n=%0d got %b exp %b", tag, n, req_ready, n == 98); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL %s err n=%0d got %b exp 0", tag, n, err); end
      if (n < last) @(posedge CLK);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, fb_wren, done, err} !== 4'b1000) begin errors++; $display("FAIL reset flags got %b exp 1000", {req_ready, fb_wren, done, err}); end
    checks++;
    if ({font_addr, fb_wraddr, fb_data} !== '0) begin errors++; $display("FAIL reset outs got %h/%h/%h exp 0", font_addr, fb_wraddr, fb_data); end
    @(negedge CLK) reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL release ready got %b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    rom_mode = 1'b0;
    send(5'd0, 4'd0, 8'h41, 1'b0);
    run_glyph("basic", 0, 8'h41, 1'b0, 98);
  endtask

  task automatic test_corner();
    rom_mode = 1'b0;
    send(5'd19, 4'd14, 8'h7E, 1'b0);
    run_glyph("corner", 8979, 8'h7E, 1'b0, 98);
  endtask

  task automatic test_reject();
    logic [4:0] cols [2] = '{5'd20, 5'd3};
    logic [3:0] rows [2] = '{4'd3, 4'd15};
    for (int t = 0; t < 2; t++) begin
      send(cols[t], rows[t], 8'h12, 1'b0);
      @(negedge CLK);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL reject%0d err got %b exp 1", t, err); end
      for (int n = 0; n < 6; n++) begin
        if (n > 0) begin
          @(negedge CLK);
          checks++;
          if (err !== 1'b0) begin errors++; $display("FAIL reject%0d err tail got %b exp 0", t, err); end
        end
        checks++;
        if (fb_wren !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL reject%0d wren/ready got %b%b exp 01", t, fb_wren, req_ready); end
      end
    end
  endtask

  task automatic test_invert();
    rom_mode = 1'b1;
    send(5'd7, 4'd2, 8'hC3, 1'b1);
    run_glyph("invert", 1287, 8'hC3, 1'b1, 98);
    rom_mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    send(5'd0, 4'd0, 8'h41, 1'b0);
    run_glyph("pre_reset", 0, 8'h41, 1'b0, 30);
    @(posedge CLK);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, fb_wren, done} !== 3'b100) begin errors++; $display("FAIL async reset got %b exp 100", {req_ready, fb_wren, done}); end
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if ({fb_wren, done} !== 2'b00) begin errors++; $display("FAIL in reset wren/done got %b exp 00", {fb_wren, done}); end
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      checks++;
      if ({req_ready, fb_wren, done} !== 3'b100) begin errors++; $display("FAIL after reset got %b exp 100", {req_ready, fb_wren, done}); end
    end
    send(5'd1, 4'd1, 8'h55, 1'b0);
    run_glyph("post_reset", 641, 8'h55, 1'b0, 98);
  endtask

  task automatic test_back_to_back();
    req_col = 5'd2; req_row = 4'd3; req_code = 8'h10; req_inv = 1'b0; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_col = 5'd4; req_row = 4'd5; req_code = 8'h22; req_inv = 1'b1;
    run_glyph("b2b_a", 1922, 8'h10, 1'b0, 98);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    run_glyph("b2b_b", 3204, 8'h22, 1'b1, 98);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_reject();
    test_invert();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
